// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int SERIAL_ADDER_DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } serial_adder_state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder slice built from two half adders; out = {carry, sum}.
module full_adder (
    input  logic [2:0] in,
    output logic [1:0] out
);

    logic s0, c0, s1, c1;

    half_adder u_ha0 (
        .a    (in[0]),
        .b    (in[1]),
        .sum  (s0),
        .carry(c0)
    );

    half_adder u_ha1 (
        .a    (s0),
        .b    (in[2]),
        .sum  (s1),
        .carry(c1)
    );

    // Both half-adder carries can never be high together, so OR is exact.
    assign out = {c0 | c1, s1};

endmodule

// File: rtl/half_adder.sv
// Combinational half adder: sum = a ^ b, carry = a & b.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder, LSB first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add the `sub` port and A-B support.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    serial_adder_state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_sr, b_sr, sum_q;
    logic             carry_reg, sub_q, carry_q, overflow_q;
    logic             sub_in, accept, last_bit, b_bit;
    logic [1:0]       fa_out;
    logic             fa_sum, fa_carry;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    assign accept   = (state_q == IDLE) && start;
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_BIT);

    // Subtraction: invert B bit by bit and let the carry-in supply the +1.
    assign b_bit = b_sr[0] ^ sub_q;

    full_adder u_fa (
        .in ({carry_reg, b_bit, a_sr[0]}),
        .out(fa_out)
    );

    assign fa_sum   = fa_out[0];
    assign fa_carry = fa_out[1];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            a_sr       <= '0;
            b_sr       <= '0;
            sum_q      <= '0;
            sub_q      <= 1'b0;
            carry_reg  <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (accept) begin
            a_sr      <= a;
            b_sr      <= b;
            sub_q     <= sub_in;
            carry_reg <= sub_in;
            cnt_q     <= '0;
        end else if (state_q == SHIFT) begin
            a_sr      <= a_sr >> 1;
            b_sr      <= b_sr >> 1;
            sum_q     <= {fa_sum, sum_q[WIDTH-1:1]};
            carry_reg <= fa_carry;
            cnt_q     <= cnt_q + 1'b1;
            // On the MSB slice carry_reg is the carry into the MSB.
            if (last_bit) begin
                carry_q    <= fa_carry;
                overflow_q <= carry_reg ^ fa_carry;
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=16): directed table, corner sequences, random sweep.
module tb_serial_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy, done, carry, overflow;
    logic [W-1:0] sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub     (sub),
`endif
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .carry   (carry),
        .overflow(overflow)
    );

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsub;
        logic [W-1:0] exp_sum;
        logic         exp_carry;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done; lat counts edges E0..E_done.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_sub,
                          output logic [W-1:0] rs, output logic rc, output logic rv,
                          output int lat);
        @(negedge clk);
        a     = op_a;
        b     = op_b;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = op_sub;
`endif
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rs = sum;
        rc = carry;
        rv = overflow;
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    logic [W-1:0] rs, ga, gb, gbb, exp_s;
    logic         rc, rv, gs, exp_c, exp_v, seen_done;
    logic [W:0]   full;
    int           lat, n;

    initial begin
        vecs.push_back('{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0});
        vecs.push_back('{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1});
        vecs.push_back('{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0});
        sub = 1'b0;
`endif

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_carry", {31'd0, carry}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, rs, rc, rv, lat);
            check($sformatf("vec%0d_latency", i), lat, 32'd17);
            check($sformatf("vec%0d_sum", i), {16'd0, rs}, {16'd0, vecs[i].exp_sum});
            check($sformatf("vec%0d_carry", i), {31'd0, rc}, {31'd0, vecs[i].exp_carry});
            check($sformatf("vec%0d_ovf", i), {31'd0, rv}, {31'd0, vecs[i].exp_ovf});
        end

        // Results hold while idle even as inputs wiggle.
        a = 16'hDEAD;
        b = 16'hBEEF;
        repeat (5) @(negedge clk);
        check("idle_stable_sum", {16'd0, sum}, {16'd0, vecs[vecs.size()-1].exp_sum});
        check("idle_stable_carry", {31'd0, carry}, {31'd0, vecs[vecs.size()-1].exp_carry});
        check("idle_stable_busy", {31'd0, busy}, 32'd0);

        // start held high: second operands ignored until the first IDLE edge.
        @(negedge clk);
        a     = 16'h0001;
        b     = 16'h0002;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 16'h0100;
        b = 16'h0200;
        n = 0;
        @(negedge clk);
        while (!done && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("hold_first_sum", {16'd0, sum}, 32'h0003);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!done && n < 40);
        start = 1'b0;
        check("hold_done_gap", n, 32'd18);
        check("hold_second_sum", {16'd0, sum}, 32'h0300);
        @(negedge clk);
        check("hold_done_pulse", {31'd0, done}, 32'd0);

        // Async reset mid-operation at bit 7.
        @(negedge clk);
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sum", {16'd0, sum}, 32'd0);
        check("abort_carry", {31'd0, carry}, 32'd0);
        check("abort_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        seen_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", {31'd0, seen_done}, 32'd0);
        run_op(16'h1234, 16'h4321, 1'b0, rs, rc, rv, lat);
        check("post_reset_sum", {16'd0, rs}, 32'h5555);
        check("post_reset_latency", lat, 32'd17);

        // Random sweep against a golden word-level add/subtract.
        for (int i = 0; i < 1000; i++) begin
            ga = W'($urandom);
            gb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            gs = 1'($urandom_range(1, 0));
`else
            gs = 1'b0;
`endif
            gbb   = gs ? ~gb : gb;
            full  = {1'b0, ga} + {1'b0, gbb} + {{W{1'b0}}, gs};
            exp_s = full[W-1:0];
            exp_c = full[W];
            exp_v = (ga[W-1] == gbb[W-1]) && (exp_s[W-1] != ga[W-1]);
            run_op(ga, gb, gs, rs, rc, rv, lat);
            check($sformatf("rand%0d a=%h b=%h sub=%0d {lat,c,v,sum}", i, ga, gb, gs),
                  {lat[13:0], rc, rv, rs}, {14'd17, exp_c, exp_v, exp_s});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
